// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: default widths, the NULL label and a small index helper.
// Also used by the reservation stations and the register file.
package cdb_arbiter_pkg;

   localparam int N_REQ_DEF   = 4;
   localparam int DATA_W_DEF  = 32;
   localparam int LABEL_W_DEF = 5;
   localparam int CNT_W_DEF   = 16;

   // Label value 0 means "no tag"; a result carrying it can never be broadcast.
   localparam int NULL_LABEL  = 0;

   // Successor of idx in a ring of n slots.
   function automatic int next_idx(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result/broadcast bundle between the execute units and the CDB arbiter.
// The requester side (execute units plus bench) is the master.
// The arbiter side is the slave.
interface cdb_arbiter_if #(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = 32,
   parameter int LABEL_W = 5,
   parameter int CNT_W   = 16
);
   logic [N_REQ-1:0]         req;
   logic [N_REQ*LABEL_W-1:0] req_label;
   logic [N_REQ*DATA_W-1:0]  req_data;
   logic [N_REQ-1:0]         grant;
   logic                     BCEN;
   logic [LABEL_W-1:0]       BClabel;
   logic [DATA_W-1:0]        BCdata;
   logic                     tag_err;
   logic [CNT_W-1:0]         bc_count;

   modport master (
      output req, req_label, req_data,
      input  grant, BCEN, BClabel, BCdata, tag_err, bc_count
   );

   modport slave (
      input  req, req_label, req_data,
      output grant, BCEN, BClabel, BCdata, tag_err, bc_count
   );
endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin picker.
// Returns the first set bit of valid, scanning upward from ptr and wrapping at N_REQ.
// The result is given both as a one-hot vector and as an index.
module cdb_arbiter_rr_picker #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // Rotating priority scan; the first hit wins and later hits are ignored.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && valid[(int'(ptr) + k) % N_REQ]) begin
            found = 1'b1;
            grant[(int'(ptr) + k) % N_REQ] = 1'b1;
            idx   = IDX_W'((int'(ptr) + k) % N_REQ);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter.
// Grants one valid result per cycle and registers it onto the BCEN/BClabel/BCdata broadcast.
// Optional macro CDB_FIXED_PRIO0_EN gives unit 0 (the load unit) absolute priority.
// Units 1..N_REQ-1 still share the remaining slots round-robin.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int LABEL_W = LABEL_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input logic           clk,
   input logic           rst,
   cdb_arbiter_if.slave  bus
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [N_REQ-1:0]   valid;
   logic [N_REQ-1:0]   null_req;
   logic [N_REQ-1:0]   pick_valid;
   logic [N_REQ-1:0]   pick_grant;
   logic [N_REQ-1:0]   win_grant;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   rr_ptr;
   logic               pick_found;
   logic               win_found;
   logic               advance;

   logic               bcen_q;
   logic [LABEL_W-1:0] label_q;
   logic [DATA_W-1:0]  data_q;
   logic               tag_err_q;
   logic [CNT_W-1:0]   count_q;

   // Split raw requests into grantable ones and ones carrying the NULL label.
   always_comb begin
      valid    = '0;
      null_req = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (bus.req[i]) begin
            if (bus.req_label[i*LABEL_W +: LABEL_W] == LABEL_W'(NULL_LABEL))
               null_req[i] = 1'b1;
            else
               valid[i] = 1'b1;
         end
      end
   end

   cdb_arbiter_rr_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .valid (pick_valid),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // Choose the winner; with fixed priority, unit 0 bypasses the ring and leaves rr_ptr alone.
   always_comb begin
`ifdef CDB_FIXED_PRIO0_EN
      pick_valid = valid & ~N_REQ'(1);
      if (valid[0]) begin
         win_grant = N_REQ'(1);
         win_idx   = '0;
         win_found = 1'b1;
         advance   = 1'b0;
      end else begin
         win_grant = pick_grant;
         win_idx   = pick_idx;
         win_found = pick_found;
         advance   = pick_found;
      end
`else
      pick_valid = valid;
      win_grant  = pick_grant;
      win_idx    = pick_idx;
      win_found  = pick_found;
      advance    = pick_found;
`endif
   end

   // Broadcast, pointer, counter and sticky error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcen_q    <= 1'b0;
         label_q   <= '0;
         data_q    <= '0;
         tag_err_q <= 1'b0;
         count_q   <= '0;
         rr_ptr    <= '0;
      end else begin
         if (|null_req)
            tag_err_q <= 1'b1;
         if (win_found) begin
            bcen_q  <= 1'b1;
            label_q <= bus.req_label[win_idx*LABEL_W +: LABEL_W];
            data_q  <= bus.req_data[win_idx*DATA_W +: DATA_W];
            count_q <= count_q + CNT_W'(1);
            if (advance)
               rr_ptr <= IDX_W'(next_idx(int'(win_idx), N_REQ));
         end else begin
            bcen_q <= 1'b0;
         end
      end
   end

   // Grant is masked during reset so no requester treats a reset cycle as accepted.
   assign bus.grant    = rst ? '0 : win_grant;
   assign bus.BCEN     = bcen_q;
   assign bus.BClabel  = label_q;
   assign bus.BCdata   = data_q;
   assign bus.tag_err  = tag_err_q;
   assign bus.bc_count = count_q;

endmodule
